// File: rtl/rl_lj_force_accumulator.sv
// Per-particle LJ force accumulator: interleaved partial sums in a pipelined FP adder,
// drained and reduced on particle_done. Requires ADD_LATENCY >= 2.
module rl_lj_force_accumulator #(
  parameter int unsigned ADD_LATENCY = 3,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 force_valid,
  input  logic [31:0]          force_x,
  input  logic [31:0]          force_y,
  input  logic [31:0]          force_z,
  input  logic                 particle_done,
  output logic                 in_ready,
  output logic                 acc_valid,
  output logic [31:0]          acc_x,
  output logic [31:0]          acc_y,
  output logic [31:0]          acc_z,
  output logic [CNT_WIDTH-1:0] acc_count,
  output logic                 drop_err
);

  localparam int unsigned IW  = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
  localparam int unsigned NXT = (ADD_LATENCY > 1) ? ADD_LATENCY - 2 : 0;

  typedef enum logic [2:0] {INIT, ACCUM, DRAIN, REDUCE, OUT} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          ph, ph_nxt, step, step_nxt;
  logic [CNT_WIDTH-1:0]   count;
  logic [2:0][31:0]       force_v, opa, opb, sum_c, add_out, add_nxt;
  logic [2:0][31:0]       pipe [ADD_LATENCY];
  logic [2:0][31:0]       part [ADD_LATENCY];
  logic                   accept, done_acc;

  // IEEE-754 single add, round-to-nearest-even, subnormals flushed to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [27:0] mx, my, s;
    logic [24:0] m;
    logic        sticky;
    int          e;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a | 32'h0040_0000;
      if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b | 32'h0040_0000;
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC0_0000;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    ex = x[30:23];
    ey = y[30:23];
    if (ex == 8'd0) return {x[31] & y[31], 31'd0};
    if (ey == 8'd0) return x;
    d  = ex - ey;
    mx = {2'b01, x[22:0], 3'b000};
    my = {2'b01, y[22:0], 3'b000};
    if (d > 8'd26) begin
      my = 28'd1;
    end else begin
      sticky = 1'b0;
      for (int i = 0; i < 27; i++) if (i < int'(d) && my[i]) sticky = 1'b1;
      my = (my >> d) | {27'd0, sticky};
    end
    s = (x[31] == y[31]) ? mx + my : mx - my;
    if (s == 28'd0) return 32'd0;
    e = int'(ex);
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 1;
    end else begin
      for (int i = 0; i < 26; i++) if (!s[26]) begin s = s << 1; e = e - 1; end
    end
    if (e <= 0) return {x[31], 31'd0};
    m = {1'b0, s[26:3]};
    if (s[2] && (s[1] | s[0] | s[3])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], 8'(e), m[22:0]};
  endfunction

  assign force_v  = {force_z, force_y, force_x};
  assign accept   = in_ready & force_valid;
  assign done_acc = in_ready & particle_done;
  assign add_out  = pipe[ADD_LATENCY-1];
  assign add_nxt  = pipe[NXT];

  // Next state and adder operand selection.
  always_comb begin
    state_nxt = state;
    ph_nxt    = ph;
    step_nxt  = step;
    opa       = '0;
    opb       = '0;
    case (state)
      INIT: begin
        ph_nxt = ph + IW'(1);
        if (ph == IW'(ADD_LATENCY - 1)) begin
          state_nxt = ACCUM;
          ph_nxt    = '0;
        end
      end
      ACCUM, OUT: begin
        opa       = accept ? force_v : '0;
        opb       = (state == ACCUM) ? add_out : '0;
        state_nxt = ACCUM;
        if (done_acc) begin
          state_nxt = DRAIN;
          ph_nxt    = '0;
        end
      end
      DRAIN: begin
        ph_nxt = ph + IW'(1);
        if (ph == IW'(ADD_LATENCY - 1)) begin
          state_nxt = REDUCE;
          ph_nxt    = '0;
          step_nxt  = IW'(1);
        end
      end
      REDUCE: begin
        if (ph == '0) begin
          opa = (step == IW'(1)) ? part[0] : add_out;
          opb = part[step];
        end
        ph_nxt = ph + IW'(1);
        if (ph == IW'(ADD_LATENCY - 1)) begin
          ph_nxt = '0;
          if (step == IW'(ADD_LATENCY - 1)) state_nxt = OUT;
          else                              step_nxt  = step + IW'(1);
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 3; i++) sum_c[i] = fp_add(opa[i], opb[i]);
  end

  // Adder pipeline and partial-sum capture; the datapath carries no reset.
  always_ff @(posedge clk) begin
    pipe[0] <= sum_c;
    for (int i = 1; i < int'(ADD_LATENCY); i++) pipe[i] <= pipe[i-1];
    if (state == DRAIN) part[ph] <= add_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      ph        <= '0;
      step      <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      acc_valid <= 1'b0;
      acc_x     <= '0;
      acc_y     <= '0;
      acc_z     <= '0;
      acc_count <= '0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ph        <= ph_nxt;
      step      <= step_nxt;
      in_ready  <= (state_nxt == ACCUM) || (state_nxt == OUT);
      acc_valid <= (state_nxt == OUT);
      drop_err  <= drop_err | ((force_valid | particle_done) & ~in_ready);
      if (state == OUT)                         count <= accept ? CNT_WIDTH'(1) : '0;
      else if (accept && count != '1)           count <= count + CNT_WIDTH'(1);
      if (state == REDUCE && state_nxt == OUT) begin
        acc_x     <= add_nxt[0];
        acc_y     <= add_nxt[1];
        acc_z     <= add_nxt[2];
        acc_count <= count;
      end
    end
  end

endmodule

// File: tb/tb_rl_lj_force_accumulator.sv
// Directed bench for rl_lj_force_accumulator with hand-computed float sums.
module tb_rl_lj_force_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        force_valid, particle_done;
  logic [31:0] force_x, force_y, force_z;
  logic        in_ready, acc_valid, drop_err;
  logic [31:0] acc_x, acc_y, acc_z;
  logic [15:0] acc_count;

  int n_cmp = 0;
  int n_bad = 0;

  rl_lj_force_accumulator #(.ADD_LATENCY(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .force_valid(force_valid), .force_x(force_x), .force_y(force_y), .force_z(force_z),
    .particle_done(particle_done), .in_ready(in_ready),
    .acc_valid(acc_valid), .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
    .acc_count(acc_count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    force_valid   = 1'b0;
    particle_done = 1'b0;
    force_x = '0; force_y = '0; force_z = '0;
  endtask

  task automatic beat(input logic fv, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    force_valid = fv; force_x = x; force_y = y; force_z = z;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, ":ready"}, 32'(in_ready), 32'd1);
  endtask

  // Drive particle_done (optionally with a beat) and check the result pulse.
  task automatic finish_particle(input string tag, input logic fv,
                                 input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                                 input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez,
                                 input logic [15:0] ecnt, input logic drain_poke,
                                 input logic out_beat, input logic [31:0] ox);
    int n;
    force_valid = fv; force_x = x; force_y = y; force_z = z;
    particle_done = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
    n = 1;
    check({tag, ":drain_ready"}, 32'(in_ready), 32'd0);
    if (drain_poke) begin force_valid = 1'b1; force_x = 32'h4228_0000; end
    while (!acc_valid && n < 40) begin
      @(posedge clk); #1;
      clear_inputs();
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'd10);
    check({tag, ":acc_x"}, acc_x, ex);
    check({tag, ":acc_y"}, acc_y, ey);
    check({tag, ":acc_z"}, acc_z, ez);
    check({tag, ":acc_count"}, 32'(acc_count), 32'(ecnt));
    check({tag, ":out_ready"}, 32'(in_ready), 32'd1);
    if (out_beat) begin force_valid = 1'b1; force_x = ox; end
    @(posedge clk); #1;
    clear_inputs();
    check({tag, ":pulse_end"}, 32'(acc_valid), 32'd0);
    check({tag, ":hold_x"}, acc_x, ex);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst:in_ready", 32'(in_ready), 32'd0);
    check("rst:acc_valid", 32'(acc_valid), 32'd0);
    check("rst:acc_x", acc_x, 32'd0);
    check("rst:acc_count", 32'(acc_count), 32'd0);
    check("rst:drop_err", 32'(drop_err), 32'd0);
    rst_n = 1'b1;
    wait_ready("init");

    // Back-to-back beats, done on the third.
    beat(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4080_0000);
    beat(1'b1, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    finish_particle("b2b", 1'b1, 32'h4080_0000, 32'h4000_0000, 32'h4080_0000,
                    32'h40E0_0000, 32'h40C0_0000, 32'h4120_0000, 16'd3, 1'b0, 1'b0, 32'd0);

    // Same beats with idle gaps and a standalone done.
    beat(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4080_0000);
    beat(1'b0, '0, '0, '0); beat(1'b0, '0, '0, '0);
    beat(1'b1, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    beat(1'b0, '0, '0, '0); beat(1'b0, '0, '0, '0);
    beat(1'b1, 32'h4080_0000, 32'h4000_0000, 32'h4080_0000);
    beat(1'b0, '0, '0, '0); beat(1'b0, '0, '0, '0);
    finish_particle("gaps", 1'b0, '0, '0, '0,
                    32'h40E0_0000, 32'h40C0_0000, 32'h4120_0000, 16'd3, 1'b0, 1'b0, 32'd0);

    // Empty particle.
    finish_particle("empty", 1'b0, '0, '0, '0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 32'd0);

    // Cancellation on X; Y sums three ones.
    beat(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h0);
    beat(1'b1, 32'hBF80_0000, 32'h3F80_0000, 32'h0);
    finish_particle("cancel", 1'b1, 32'h4000_0000, 32'h3F80_0000, 32'h0,
                    32'h4000_0000, 32'h4040_0000, 32'h0, 16'd3, 1'b0, 1'b0, 32'd0);
    check("cancel:no_drop", 32'(drop_err), 32'd0);

    // Beat during DRAIN is dropped; beat in the OUT cycle is kept.
    finish_particle("drop", 1'b1, 32'h3F80_0000, 32'h0, 32'h0,
                    32'h3F80_0000, 32'h0, 32'h0, 16'd1, 1'b1, 1'b1, 32'h40A0_0000);
    check("drop:drop_err", 32'(drop_err), 32'd1);
    beat(1'b1, 32'h4000_0000, 32'h0, 32'h0);
    finish_particle("after_out", 1'b0, '0, '0, '0,
                    32'h40E0_0000, 32'h0, 32'h0, 16'd2, 1'b0, 1'b0, 32'd0);
    check("after_out:drop_sticky", 32'(drop_err), 32'd1);

    // Reset in the middle of REDUCE abandons the particle.
    force_valid = 1'b1; force_x = 32'h4110_0000; particle_done = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst:in_ready", 32'(in_ready), 32'd0);
    check("midrst:acc_valid", 32'(acc_valid), 32'd0);
    check("midrst:acc_x", acc_x, 32'd0);
    check("midrst:acc_count", 32'(acc_count), 32'd0);
    check("midrst:drop_err", 32'(drop_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (acc_valid) pulses++;
    end
    check("midrst:no_pulse", 32'(pulses), 32'd0);
    wait_ready("midrst");
    finish_particle("post_rst", 1'b1, 32'h4040_0000, 32'h0, 32'h0,
                    32'h4040_0000, 32'h0, 32'h0, 16'd1, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
